// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO in front of a UART driver. Bytes come in
// over a valid/ready port and go out one at a time as a one-cycle start pulse.
// The sequencer waits for the driver to raise and drop busy before it launches
// the next byte. Overflow and launch-timeout errors are sticky.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    output logic [DATA_WIDTH-1:0]    uart_data_in,
    output logic                     uart_start,
    input  logic                     uart_ready,
    input  logic                     uart_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic                     timeout_err,
    input  logic                     clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, ARM, WAIT_DONE} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [TW-1:0]           timer;
    logic                    push;
    logic                    pop;

    // Flags come straight from the registered count, so they reflect the
    // previous edge; wr_ready therefore never sees a same-cycle pop.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign wr_ready   = rst && !fifo_full;

    assign push = wr_valid && wr_ready;
    assign pop  = (state == IDLE) && !fifo_empty && uart_ready;

    // Storage write; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow: a write offered while full is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst)
            overflow <= 1'b0;
        else if (wr_valid && fifo_full)
            overflow <= 1'b1;
        else if (clear_err)
            overflow <= 1'b0;
    end

    // Launch sequencer: pop, pulse start, wait for busy to rise then fall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            uart_start   <= 1'b0;
            uart_data_in <= '0;
            timer        <= '0;
            timeout_err  <= 1'b0;
        end else begin
            uart_start <= 1'b0;
            // Cleared first so a timeout in this same cycle overrides it.
            if (clear_err)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        uart_data_in <= mem[rd_ptr];
                        uart_start   <= 1'b1;
                        timer        <= '0;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: state <= ARM;
                ARM: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_LAST) begin
                        // Driver never took the byte; drop it, no retry.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus a randomized run, with a queue-based
// reference model compared against the DUT every cycle and a behavioural
// driver that answers each start pulse with a busy window.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int BT    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [DW-1:0] uart_data_in;
    logic          uart_start;
    logic          uart_ready = 1'b1;
    logic          uart_busy = 1'b0;
    logic [4:0]    fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;
    logic          timeout_err;
    logic          clear_err = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .uart_data_in(uart_data_in), .uart_start(uart_start),
        .uart_ready(uart_ready), .uart_busy(uart_busy), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
        .timeout_err(timeout_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Behavioural driver state.
    bit hold = 1'b0;
    bit rnd_len = 1'b0;
    int drv_len = 5;
    int drv_left = 0;
    bit drv_busy = 1'b0;
    bit saw_start = 1'b0;
    logic [DW-1:0] seen[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc_n);
        end
    endtask

    task automatic drv_apply();
        uart_busy  = drv_busy;
        uart_ready = !drv_busy && !hold;
    endtask

    // Busy is high for the chosen length starting the cycle after start.
    task automatic drv_step();
        if (saw_start)
            drv_left = rnd_len ? (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)))
                               : drv_len;
        drv_busy = (drv_left > 0);
        if (drv_left > 0)
            drv_left--;
    endtask

    task automatic cyc();
        @(negedge clk);
        saw_start = (uart_start === 1'b1);
        if (saw_start)
            seen.push_back(uart_data_in);
        @(posedge clk);
        #1;
        cyc_n++;
        drv_step();
        drv_apply();
    endtask

    // Reference model: FIFO as a queue, sequencer as launch age and ack flag.
    logic [DW-1:0] q[$];
    bit            mv = 1'b0;
    bit            m_free = 1'b1;
    bit            m_ack = 1'b0;
    int            m_age = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_start = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_tmo = 1'b0;
    int            m_sz;
    bit            m_pop;

    always @(negedge clk) begin
        if (mv) begin
            chk("m_start", {31'd0, uart_start}, {31'd0, m_start});
            chk("m_data", {24'd0, uart_data_in}, {24'd0, m_data});
            chk("m_count", {27'd0, fifo_count}, q.size());
            chk("m_empty", {31'd0, fifo_empty}, {31'd0, q.size() == 0});
            chk("m_full", {31'd0, fifo_full}, {31'd0, q.size() == DEPTH});
            chk("m_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("m_timeout", {31'd0, timeout_err}, {31'd0, m_tmo});
            chk("m_wr_ready", {31'd0, wr_ready}, {31'd0, rst && (q.size() < DEPTH)});
        end
        if (!rst) begin
            q.delete();
            m_free = 1'b1; m_ack = 1'b0; m_age = 0; m_data = '0;
            m_start = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; mv = 1'b1;
        end else if (mv) begin
            m_sz  = q.size();
            m_pop = m_free && (m_sz > 0) && uart_ready;
            if (clear_err) begin m_ovf = 1'b0; m_tmo = 1'b0; end
            if (wr_valid && m_sz == DEPTH) m_ovf = 1'b1;
            if (!m_free) begin
                if (m_age >= 1 && !m_ack) begin
                    if (uart_busy) m_ack = 1'b1;
                    else if (m_age == BT) begin m_tmo = 1'b1; m_free = 1'b1; end
                end else if (m_ack && !uart_busy) begin
                    m_free = 1'b1;
                end
                m_age++;
            end
            m_start = m_pop;
            if (m_pop) begin
                m_data = q.pop_front();
                m_free = 1'b0; m_ack = 1'b0; m_age = 0;
            end
            if (wr_valid && m_sz < DEPTH) q.push_back(wr_data);
        end
    end

    initial begin
        bit found;
        int s2;

        // Reset with a write offered: nothing may be pushed.
        rst = 1'b0; wr_valid = 1'b1; wr_data = 8'h77;
        repeat (3) cyc();
        chk("rst_count", {27'd0, fifo_count}, 0);
        chk("rst_empty", {31'd0, fifo_empty}, 1);
        chk("rst_full", {31'd0, fifo_full}, 0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 0);
        chk("rst_start", {31'd0, uart_start}, 0);
        chk("rst_data", {24'd0, uart_data_in}, 0);
        chk("rst_flags", {30'd0, overflow, timeout_err}, 0);
        rst = 1'b1; wr_valid = 1'b0;
        repeat (2) cyc();

        // Single byte: start two cycles after the accepting cycle.
        drv_len = 5;
        wr_valid = 1'b1; wr_data = 8'hA5;
        cyc();
        wr_valid = 1'b0;
        chk("single_count1", {27'd0, fifo_count}, 1);
        chk("single_nostart", {31'd0, uart_start}, 0);
        cyc();
        chk("single_start", {31'd0, uart_start}, 1);
        chk("single_data", {24'd0, uart_data_in}, 8'hA5);
        chk("single_count0", {27'd0, fifo_count}, 0);
        repeat (12) cyc();
        chk("single_noerr", {30'd0, overflow, timeout_err}, 0);

        // Burst to full, one dropped write, then in-order drain.
        hold = 1'b1; drv_apply();
        for (int i = 1; i <= 16; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            cyc();
        end
        chk("burst_full", {31'd0, fifo_full}, 1);
        chk("burst_count", {27'd0, fifo_count}, 16);
        wr_data = 8'h11;
        cyc();
        wr_valid = 1'b0;
        chk("burst_overflow", {31'd0, overflow}, 1);
        chk("burst_count_kept", {27'd0, fifo_count}, 16);
        seen.delete();
        drv_len = 1; hold = 1'b0; drv_apply();
        repeat (100) cyc();
        chk("burst_seen_n", seen.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < seen.size()) chk("burst_order", {24'd0, seen[i]}, i + 1);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        chk("burst_clear", {31'd0, overflow}, 0);

        // Push and pop on the same edge with three entries held.
        drv_len = 2; hold = 1'b1; drv_apply();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h21 + i);
            cyc();
        end
        wr_valid = 1'b0;
        repeat (2) cyc();
        chk("simul_pre", {27'd0, fifo_count}, 3);
        seen.delete();
        hold = 1'b0; drv_apply();
        wr_valid = 1'b1; wr_data = 8'h24;
        cyc();
        wr_valid = 1'b0;
        chk("simul_count", {27'd0, fifo_count}, 3);
        chk("simul_start", {31'd0, uart_start}, 1);
        chk("simul_data", {24'd0, uart_data_in}, 8'h21);
        repeat (40) cyc();
        chk("simul_seen_n", seen.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen.size()) chk("simul_order", {24'd0, seen[i]}, 8'h21 + i);

        // Timeout: busy never rises.
        drv_len = 0;
        wr_valid = 1'b1; wr_data = 8'h3C;
        cyc();
        wr_data = 8'h3D;
        cyc();
        wr_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (uart_start === 1'b1) found = 1'b1;
            else cyc();
        end
        if (!found) begin
            errors++;
            $display("FAIL tmo_wait_start actual=none required=start within 10 cycles");
        end else begin
            chk("tmo_data", {24'd0, uart_data_in}, 8'h3C);
            repeat (16) cyc();
            chk("tmo_early", {31'd0, timeout_err}, 0);
            cyc();
            chk("tmo_set", {31'd0, timeout_err}, 1);
            found = 1'b0;
            s2 = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                if (uart_start === 1'b1) found = 1'b1;
                else begin cyc(); s2++; end
            end
            chk("tmo_next_launch", {31'd0, found}, 1);
            chk("tmo_next_gap", s2, 1);
            chk("tmo_next_data", {24'd0, uart_data_in}, 8'h3D);
        end
        repeat (20) cyc();
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;

        // Reset while the driver is busy with five bytes still queued.
        drv_len = 8; hold = 1'b1; drv_apply();
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1; wr_data = 8'(8'h41 + i);
            cyc();
        end
        wr_valid = 1'b0;
        hold = 1'b0; drv_apply();
        repeat (4) cyc();
        chk("midrst_pre", {27'd0, fifo_count}, 5);
        rst = 1'b0;
        cyc();
        chk("midrst_count", {27'd0, fifo_count}, 0);
        chk("midrst_empty", {31'd0, fifo_empty}, 1);
        chk("midrst_start", {31'd0, uart_start}, 0);
        rst = 1'b1;
        seen.delete();
        repeat (20) cyc();
        chk("midrst_quiet", seen.size(), 0);
        wr_valid = 1'b1; wr_data = 8'h55;
        cyc();
        wr_valid = 1'b0;
        cyc();
        chk("midrst_relaunch", {31'd0, uart_start}, 1);
        chk("midrst_data", {24'd0, uart_data_in}, 8'h55);
        repeat (12) cyc();

        // Randomized traffic, driver lengths, ready stalls, clears and resets.
        rnd_len = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 399) != 0);
            wr_valid  = ($urandom_range(0, 9) < 4);
            wr_data   = 8'($urandom);
            clear_err = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) hold = !hold;
            drv_apply();
            cyc();
        end
        rst = 1'b1; wr_valid = 1'b0; clear_err = 1'b0;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch sequencer that sits directly upstream of the UART driver. It accepts bytes from a host through a valid/ready write port and stores them in a circular FIFO. It then presents them one at a time to the driver's `data_in` / `UART_Start` inputs, pacing itself on the driver's `UART_Ready` / `UART_Busy` outputs. It also flags overflow and flags a driver that never acknowledges a launch.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DATA_WIDTH`, 8: byte width; must match the driver's `data_in`.
- `BUSY_TIMEOUT`, 16: cycles allowed in ARM for the driver to raise busy; ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `wr_valid`  in  1  host offers `wr_data`.
- `wr_data`  in  DATA_WIDTH  byte to enqueue.
- `wr_ready`  out  1  FIFO can accept; equals not full and not in reset.
- `uart_data_in`  out  DATA_WIDTH  byte to driver; drives driver `data_in`.
- `uart_start`  out  1  one-cycle launch pulse; drives driver `UART_Start`.
- `uart_ready`  in  1  from driver `UART_Ready`.
- `uart_busy`  in  1  from driver `UART_Busy`.
- `fifo_count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- `fifo_empty`  out  1  count == 0.
- `fifo_full`  out  1  count == DEPTH.
- `overflow`  out  1  sticky: write attempted while full.
- `timeout_err`  out  1  sticky: driver never asserted busy after a launch.
- `clear_err`  in  1  clears both sticky flags.

## Operation
- **Storage:** DEPTH×DATA_WIDTH array, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `fifo_count` is registered.
- **Push:** occurs when `wr_valid && wr_ready`. If `wr_valid && fifo_full`, the byte is dropped, `overflow` is set, and the pointers are unchanged.
- **Simultaneous push and pop:** both pointers advance and the count is unchanged. A full FIFO never accepts a write in the cycle it pops, because `wr_ready` uses the registered full flag.
- **No bypass:** a byte written to an empty FIFO is visible to the FSM on the next cycle.
- **FSM states and transitions:**
  - IDLE → LAUNCH when `!fifo_empty && uart_ready`. On that edge: pop the head into `uart_data_in`, set `uart_start` to 1, clear the timeout counter.
  - LAUNCH (one cycle) → ARM. `uart_start` returns to 0 on exit.
  - ARM:
    - If `uart_busy` = 1, go to WAIT_DONE.
    - Otherwise increment the counter.
    - When the counter reaches BUSY_TIMEOUT, set `timeout_err` and go to IDLE. The byte is discarded and not retried.
  - WAIT_DONE → IDLE when `uart_busy` = 0.
- **`uart_data_in`:** holds its value until the next launch.
- **`clear_err`:** clears `overflow` and `timeout_err`. If a new error occurs in the same cycle, set wins.
- **Arithmetic:** the count update is +1, −1 or 0, with no saturation beyond 0..DEPTH. This is guaranteed by the wr_ready and empty gating.

## Timing
- **Reset (`rst` = 0 at an edge):**
  - Pointers and count are 0; state is IDLE.
  - `uart_data_in` = 0, `uart_start` = 0, `overflow` = 0, `timeout_err` = 0.
  - `fifo_empty` = 1, `fifo_full` = 0, `wr_ready` = 0 while `rst` is low.
- **Reset mid-operation:** the FIFO contents are flushed. `uart_start` is low from the next edge. A frame already inside the driver is unaffected.
- **Latency:** a write accepted in cycle k, with the FSM in IDLE and `uart_ready` = 1, produces `uart_start` high in cycle k+2.
- **Pulse width:** `uart_start` is high for exactly 1 cycle per popped byte. It never reasserts before the FSM returns to IDLE.
- **Back-to-back launches:** the minimum spacing between `uart_start` pulses is 4 cycles (LAUNCH, ARM, WAIT_DONE, IDLE), even with a driver whose busy lasts one cycle.
- **Timeout:** if busy never rises, `timeout_err` is high exactly BUSY_TIMEOUT+1 cycles after the `uart_start` cycle.
- **Status outputs:** flags and count are registered and reflect the push/pop of the previous edge.

## Test plan
- **Reset values:** hold `rst` = 0 for 3 cycles with `wr_valid` = 1 → all outputs at reset values, `wr_ready` = 0, no push.
- **Single byte:** write 0xA5 into an empty FIFO; model the driver with busy high for 5 cycles starting the cycle after start → `uart_start` high in cycle k+2, `uart_data_in` = 0xA5, `fifo_count` returns to 0, no errors.
- **Burst and ordering:** write 0x01..0x10 back-to-back (DEPTH = 16) → `fifo_full` = 1 after the 16th. A 17th write (0x11) sets `overflow` and is dropped. The driver then sees 0x01..0x10 in order. Pulse `clear_err` → `overflow` = 0.
- **Simultaneous push/pop:** with count = 3, push in the same cycle as a pop → count stays 3 and ordering is preserved.
- **Timeout:** tie `uart_busy` = 0 and `uart_ready` = 1, write 0x3C → `timeout_err` = 1 at start cycle + 17. The FSM returns to IDLE and launches the next queued byte.
- **Reset mid-stream:** assert `rst` low while in WAIT_DONE with 5 bytes queued → next cycle count = 0, `fifo_empty` = 1, no `uart_start` after release until a new write.
